// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles an MSB-first byte stream into 32-bit words and writes them
// at consecutive word addresses while holding the CPU in reset. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int          DEPTH    = 256,
   parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [8:0]  len,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [31:0] wr_adr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        cpu_hold
);

   localparam logic [8:0] DEPTH_L = 9'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [8:0]  eff_len;
   logic [8:0]  word_cnt;
   logic [1:0]  byte_cnt;
   logic [23:0] shift;
   logic [8:0]  len_clip;
   logic        start_ok;
   logic        accept;
   logic        last_byte;

   assign len_clip  = (len > DEPTH_L) ? DEPTH_L : len;
   assign start_ok  = start && (state == S_IDLE || state == S_DONE);
   assign accept    = byte_valid && byte_ready;
   assign last_byte = accept && (byte_cnt == 2'd3);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      busy       = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (len_clip != 9'd0) state_nxt = S_RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
               else                  state_nxt = S_CHK;
`else
               else                  state_nxt = S_DONE;
`endif
            end
         end
         S_RECV: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid && byte_cnt == 2'd3) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            busy = 1'b1;
            if (word_cnt + 9'd1 == eff_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = S_CHK;
`else
               state_nxt = S_DONE;
`endif
            end else begin
               state_nxt = S_RECV;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid && byte_cnt == 2'd3) state_nxt = S_DONE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   assign wr_en    = (state == S_WRITE);
   assign done     = (state == S_DONE);
   assign cpu_hold = busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eff_len  <= '0;
         word_cnt <= '0;
         byte_cnt <= '0;
         shift    <= '0;
         wr_adr   <= BASE_ADR;
         wr_data  <= '0;
      end else begin
         if (start_ok) begin
            eff_len  <= len_clip;
            word_cnt <= '0;
            byte_cnt <= '0;
         end
         if (accept) begin
            shift    <= {shift[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
         end
         // Address and data are captured with the 4th byte and then held until the next word.
         if (last_byte && state == S_RECV) begin
            wr_adr  <= BASE_ADR + {21'd0, word_cnt, 2'b00};
            wr_data <= {shift, byte_in};
         end
         if (state == S_WRITE) word_cnt <= word_cnt + 9'd1;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
         err <= 1'b0;
      end else begin
         if (start_ok) begin
            sum <= '0;
            err <= 1'b0;
         end
         if (state == S_WRITE) sum <= sum + wr_data;
         if (last_byte && state == S_CHK && {shift, byte_in} != sum) err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a negedge monitor checks them.
module tb_imem_loader;

   logic        clk, rst, start, byte_valid;
   logic [8:0]  len;
   logic [7:0]  byte_in;
   logic        byte_ready, wr_en, busy, done, err, cpu_hold;
   logic [31:0] wr_adr, wr_data;

   imem_loader dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
      .wr_adr(wr_adr), .wr_data(wr_data), .busy(busy), .done(done),
      .err(err), .cpu_hold(cpu_hold)
   );

   typedef struct {
      logic [31:0] adr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  wr_cnt = 0;
   int  first_wr = -1;
   int  s_cyc = 0;
   int  wc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every write strobe.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wr_cnt++;
         if (first_wr < 0) first_wr = cyc;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got adr 0x%08h data 0x%08h expected no write", wr_adr, wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_adr", wr_adr, e.adr);
            check("wr_data", wr_data, e.data);
         end
      end
   end

   task automatic push(input logic [31:0] adr, input logic [31:0] data);
      wr_t e;
      e.adr  = adr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
      check({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
      check({tag, "_wr_adr"},     wr_adr,              32'd0);
      check({tag, "_wr_data"},    wr_data,             32'd0);
      check({tag, "_busy"},       {31'd0, busy},       32'd0);
      check({tag, "_done"},       {31'd0, done},       32'd0);
      check({tag, "_err"},        {31'd0, err},        32'd0);
      check({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd0);
   endtask

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic do_start(input logic [8:0] l);
      start = 1'b1;
      len   = l;
      first_wr = -1;
      wc = wr_cnt;
      @(posedge clk);
      #1;
      start = 1'b0;
      s_cyc = cyc;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (byte_ready === 1'b1) break;
         n++;
         if (n > 50) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: got byte_ready=0 for 50 cycles expected 1");
            @(posedge clk);
            #1;
            return;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
   endtask

   task automatic end_load(input logic [31:0] chk_word, input logic exp_err);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(chk_word);
`else
      @(posedge clk);
      #1;
`endif
      byte_valid = 1'b0;
      @(negedge clk);
      check("end_done",       {31'd0, done},       32'd1);
      check("end_cpu_hold",   {31'd0, cpu_hold},   32'd0);
      check("end_busy",       {31'd0, busy},       32'd0);
      check("end_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("end_err",        {31'd0, err},        {31'd0, exp_err});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; byte_in = '0; byte_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("rst");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_vals("idle");

      // Two words, back-to-back bytes.
      push(32'h0, 32'h1234_5678);
      push(32'h4, 32'h9ABC_DEF0);
      do_start(9'd2);
      check("start_byte_ready", {31'd0, byte_ready}, 32'd1);
      check("start_cpu_hold",   {31'd0, cpu_hold},   32'd1);
      send_word(32'h1234_5678);
      send_word(32'h9ABC_DEF0);
      end_load(32'hACF1_3568, 1'b0);
      check("b2b_first_wr_cyc", first_wr, s_cyc + 4);
      check("b2b_wr_count", wr_cnt - wc, 32'd2);

      // Same load with a 3-cycle gap after byte 2.
      push(32'h0, 32'h1234_5678);
      push(32'h4, 32'h9ABC_DEF0);
      do_start(9'd2);
      send_byte(8'h12);
      send_byte(8'h34);
      byte_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("gap_no_early_wr", wr_cnt - wc, 32'd0);
      send_byte(8'h56);
      send_byte(8'h78);
      send_word(32'h9ABC_DEF0);
      end_load(32'hACF1_3568, 1'b0);
      check("gap_first_wr_cyc", first_wr, s_cyc + 7);
      check("gap_wr_count", wr_cnt - wc, 32'd2);

      // Zero-length load.
      do_start(9'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("len0_chk_ready", {31'd0, byte_ready}, 32'd1);
`else
      check("len0_done_next", {31'd0, done}, 32'd1);
`endif
      end_load(32'h0, 1'b0);
      check("len0_wr_count", wr_cnt - wc, 32'd0);

      // start (with a different len) during RECV is ignored.
      push(32'h0, 32'h1122_3344);
      push(32'h4, 32'h5566_7788);
      do_start(9'd2);
      send_byte(8'h11);
      send_byte(8'h22);
      start = 1'b1;
      len   = 9'd1;
      send_byte(8'h33);
      start = 1'b0;
      send_byte(8'h44);
      send_word(32'h5566_7788);
      end_load(32'h6688_AACC, 1'b0);
      check("ign_wr_count", wr_cnt - wc, 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum mismatch then match.
      push(32'h0, 32'h0000_0005);
      do_start(9'd1);
      send_word(32'h0000_0005);
      end_load(32'h0000_0006, 1'b1);
      push(32'h0, 32'h0000_0005);
      do_start(9'd1);
      send_word(32'h0000_0005);
      end_load(32'h0000_0005, 1'b0);
`endif

      // Asynchronous reset in the middle of word 1 of a 3-word load.
      push(32'h0, 32'hCAFE_F00D);
      do_start(9'd3);
      send_word(32'hCAFE_F00D);
      send_byte(8'h01);
      send_byte(8'h02);
      rst = 1'b1;
      #1;
      check_reset_vals("midrst");
      byte_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_wr_count", wr_cnt - wc, 32'd1);
      push(32'h0, 32'hA5A5_A5A5);
      do_start(9'd1);
      send_word(32'hA5A5_A5A5);
      end_load(32'hA5A5_A5A5, 1'b0);
      check("reload_wr_count", wr_cnt - wc, 32'd1);

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
